// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: jump-type codes and fetch FSM state encoding, shared by fetch and decode.
// Latency: n/a (constants only).
// Backpressure: n/a.
package fetch_unit_pkg;

  // Jump-type codes as produced by decode and resolved on the execute side.
  localparam logic [2:0] J_TYPE_NOP  = 3'b000;
  localparam logic [2:0] J_TYPE_BEQ  = 3'b001;
  localparam logic [2:0] J_TYPE_JAL  = 3'b010;
  localparam logic [2:0] J_TYPE_JR   = 3'b011;
  localparam logic [2:0] J_TYPE_J    = 3'b100;
  localparam logic [2:0] J_TYPE_BGTZ = 3'b101;

  // Fetch FSM states.
  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

endpackage

// File: rtl/next_pc_calc.sv
// next_pc_calc: branch/jump resolution -> taken flag and redirect target.
// Latency: purely combinational.
// Backpressure: none.
// Ports: br_jump_type/br_pc/br_imm/br_jump_addr/br_rs1/br_zero in; taken, target out.
module next_pc_calc #(
  parameter int DWIDTH = 32
) (
  input  logic [2:0]        br_jump_type,
  input  logic [DWIDTH-1:0] br_pc,
  input  logic [DWIDTH-1:0] br_imm,
  input  logic [25:0]       br_jump_addr,
  input  logic [DWIDTH-1:0] br_rs1,
  input  logic              br_zero,
  output logic              taken,
  output logic [DWIDTH-1:0] target
);
  import fetch_unit_pkg::*;

  logic [DWIDTH-1:0] pc_plus4;
  logic [DWIDTH-1:0] br_target;
  logic [DWIDTH-1:0] j_target;
  logic [DWIDTH-1:0] jr_target;
  logic [DWIDTH-1:0] region_mask;

  assign pc_plus4    = br_pc + DWIDTH'(4);
  assign br_target   = pc_plus4 + (br_imm << 2);
  // J/JAL keep the top nibble of the link address (region) and splice in the word index.
  assign region_mask = {{4{1'b1}}, {(DWIDTH-4){1'b0}}};
  assign j_target    = (pc_plus4 & region_mask) | {{(DWIDTH-28){1'b0}}, br_jump_addr, 2'b00};
  assign jr_target   = {br_rs1[DWIDTH-1:2], 2'b00};

  always_comb begin
    taken  = 1'b0;
    target = br_target;
    case (br_jump_type)
      J_TYPE_BEQ:  taken = br_zero;
      J_TYPE_BGTZ: taken = ($signed(br_rs1) > $signed({DWIDTH{1'b0}}));
      J_TYPE_J,
      J_TYPE_JAL: begin
        taken  = 1'b1;
        target = j_target;
      end
      J_TYPE_JR: begin
        taken  = 1'b1;
        target = jr_target;
      end
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: owns the PC, issues one imem request at a time, presents {instr, pc, pc+4} to decode.
// Latency: 3 cycles per instruction with single-cycle gnt and rvalid (FETCH -> WAIT -> HOLD).
// Backpressure: holds the word in S_HOLD until out_ready; no new request issued while held.
// Ports: clk/rst; imem_req/addr/gnt/rvalid/rdata; out_valid/ready/instr/pc/pc_plus4;
//        br_valid/jump_type/pc/imm/jump_addr/rs1/zero from execute.
module fetch_unit #(
  parameter int                DWIDTH   = 32,
  parameter logic [DWIDTH-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [DWIDTH-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [DWIDTH-1:0] imem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DWIDTH-1:0] out_instr,
  output logic [DWIDTH-1:0] out_pc,
  output logic [DWIDTH-1:0] out_pc_plus4,
  input  logic              br_valid,
  input  logic [2:0]        br_jump_type,
  input  logic [DWIDTH-1:0] br_pc,
  input  logic [DWIDTH-1:0] br_imm,
  input  logic [25:0]       br_jump_addr,
  input  logic [DWIDTH-1:0] br_rs1,
  input  logic              br_zero
);
  import fetch_unit_pkg::*;

  localparam logic [DWIDTH-1:0] PC_INC = DWIDTH'(4);

  logic [1:0]        state_q, state_d;
  logic [DWIDTH-1:0] pc_q, pc_d;
  logic              kill_q, kill_d;
  logic [DWIDTH-1:0] instr_q, instr_d;
  logic [DWIDTH-1:0] out_pc_q, out_pc_d;
  logic [DWIDTH-1:0] out_pc_plus4_q, out_pc_plus4_d;

  logic              taken;
  logic [DWIDTH-1:0] target;
  logic              redirect;

  next_pc_calc #(.DWIDTH(DWIDTH)) u_next_pc_calc (
    .br_jump_type (br_jump_type),
    .br_pc        (br_pc),
    .br_imm       (br_imm),
    .br_jump_addr (br_jump_addr),
    .br_rs1       (br_rs1),
    .br_zero      (br_zero),
    .taken        (taken),
    .target       (target)
  );

  assign redirect = br_valid & taken;

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    kill_d         = kill_q;
    instr_d        = instr_q;
    out_pc_d       = out_pc_q;
    out_pc_plus4_d = out_pc_plus4_q;
    case (state_q)
      S_FETCH: begin
        if (redirect) pc_d = target;
        if (imem_gnt) begin
          state_d = S_WAIT;
          // A granted request for the old PC is now wrong-path; drop its response.
          kill_d  = redirect;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          if (kill_q || redirect) begin
            kill_d  = 1'b0;
            state_d = S_FETCH;
            if (redirect) pc_d = target;
          end else begin
            instr_d        = imem_rdata;
            out_pc_d       = pc_q;
            out_pc_plus4_d = pc_q + PC_INC;
            pc_d           = pc_q + PC_INC;
            state_d        = S_HOLD;
          end
        end else if (redirect) begin
          pc_d   = target;
          kill_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (redirect) begin
          pc_d    = target;
          state_d = S_FETCH;
        end else if (out_ready) begin
          state_d = S_FETCH;
        end
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_FETCH;
      pc_q           <= RESET_PC;
      kill_q         <= 1'b0;
      instr_q        <= '0;
      out_pc_q       <= '0;
      out_pc_plus4_q <= '0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      kill_q         <= kill_d;
      instr_q        <= instr_d;
      out_pc_q       <= out_pc_d;
      out_pc_plus4_q <= out_pc_plus4_d;
    end
  end

  assign imem_req     = (state_q == S_FETCH) & ~rst;
  assign imem_addr    = pc_q;
  // A word being flushed this cycle must never look accepted to decode.
  assign out_valid    = (state_q == S_HOLD) & ~redirect;
  assign out_instr    = instr_q;
  assign out_pc       = out_pc_q;
  assign out_pc_plus4 = out_pc_plus4_q;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr, out_pc, out_pc_plus4;
  logic        br_valid = 1'b0;
  logic [2:0]  br_jump_type = '0;
  logic [31:0] br_pc = '0, br_imm = '0, br_rs1 = '0;
  logic [25:0] br_jump_addr = '0;
  logic        br_zero = 1'b0;

  fetch_unit dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .out_pc_plus4(out_pc_plus4),
    .br_valid(br_valid), .br_jump_type(br_jump_type), .br_pc(br_pc), .br_imm(br_imm),
    .br_jump_addr(br_jump_addr), .br_rs1(br_rs1), .br_zero(br_zero)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] p4;
    logic [31:0] exp;
  } acc_t;

  int checks = 0;
  int errors = 0;

  // memory / environment model state
  bit          pend;
  int          pend_cnt;
  logic [31:0] pend_addr;
  int          gnt_pct = 100;
  int          dly_min = 0;
  int          dly_max = 0;
  bit          ready_set = 1'b1;
  bit          nb_valid;
  logic [2:0]  nb_type;
  logic [31:0] nb_pc, nb_imm, nb_rs1;
  logic [25:0] nb_ja;
  bit          nb_zero;

  // reference stream: next PC decode should see
  logic [31:0] exp_pc;
  acc_t        acc_q[$];
  int          acc_gap_q[$];
  logic [31:0] gnt_addr_q[$];
  int          flush_viol, overlap_viol, cyc, last_acc_cyc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'hC3A5_5A3C;
  endfunction

  // Branch semantics from the ISA rules, in plain arithmetic.
  function automatic void ref_br(input logic [2:0] jt, input logic [31:0] pc, input logic [31:0] imm,
                                 input logic [31:0] rs1, input logic [25:0] ja, input logic zero,
                                 output bit tk, output logic [31:0] tg);
    logic [31:0] link;
    link = pc + 32'd4;
    tk = 1'b0;
    tg = '0;
    case (jt)
      3'b001: begin tk = zero; tg = link + imm * 32'd4; end
      3'b101: begin tk = ($signed(rs1) > 32'sd0); tg = link + imm * 32'd4; end
      3'b010, 3'b100: begin tk = 1'b1; tg = (link & 32'hF000_0000) | ({6'd0, ja} * 32'd4); end
      3'b011: begin tk = 1'b1; tg = rs1 - (rs1 % 32'd4); end
      default: tk = 1'b0;
    endcase
  endfunction

  task automatic cycle();
    bit          g;
    logic [31:0] a;
    bit          tk;
    logic [31:0] tg;
    g = imem_req && imem_gnt;
    a = imem_addr;
    @(posedge clk);
    cyc++;
    if (g) begin
      pend = 1'b1;
      pend_addr = a;
      pend_cnt = $urandom_range(dly_min, dly_max);
      gnt_addr_q.push_back(a);
    end
    #1;
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    if (pend) begin
      if (pend_cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(pend_addr);
        pend = 1'b0;
      end else begin
        pend_cnt--;
      end
    end
    imem_gnt = !pend && ($urandom_range(0, 99) < gnt_pct);
    out_ready = ready_set;
    br_valid = nb_valid;
    br_jump_type = nb_type; br_pc = nb_pc; br_imm = nb_imm;
    br_rs1 = nb_rs1; br_jump_addr = nb_ja; br_zero = nb_zero;
    nb_valid = 1'b0;
    #1;
    ref_br(br_jump_type, br_pc, br_imm, br_rs1, br_jump_addr, br_zero, tk, tg);
    if (br_valid && tk) begin
      if (out_valid) flush_viol++;
      exp_pc = tg;
    end else if (out_valid && out_ready) begin
      acc_q.push_back({out_pc, out_instr, out_pc_plus4, exp_pc});
      acc_gap_q.push_back(cyc - last_acc_cyc);
      last_acc_cyc = cyc;
      exp_pc = exp_pc + 32'd4;
    end
    if (imem_req && pend) overlap_viol++;
  endtask

  task automatic stage_br(input logic [2:0] jt, input logic [31:0] pc, input logic [31:0] imm,
                          input logic [31:0] rs1, input logic [25:0] ja, input bit zero);
    nb_valid = 1'b1; nb_type = jt; nb_pc = pc; nb_imm = imm;
    nb_rs1 = rs1; nb_ja = ja; nb_zero = zero;
  endtask

  task automatic run_until_acc(input int n, input int bound, input string name);
    int k;
    k = 0;
    while (acc_q.size() < n && k < bound) begin
      cycle();
      k++;
    end
    if (acc_q.size() < n) begin
      checks++; errors++;
      $display("FAIL %s timeout: got %0d accepted words, need %0d", name, acc_q.size(), n);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; br_valid = 1'b0; nb_valid = 1'b0;
    pend = 1'b0; gnt_pct = 100; dly_min = 0; dly_max = 0; ready_set = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    exp_pc = 32'h0;
    acc_q.delete(); acc_gap_q.delete(); gnt_addr_q.delete();
    flush_viol = 0; overlap_viol = 0; last_acc_cyc = cyc;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    checks++;
    if (imem_req !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_ctrl: req=%b valid=%b, need 0/0", imem_req, out_valid);
    end
    checks++;
    if (out_instr !== 32'h0 || out_pc !== 32'h0 || out_pc_plus4 !== 32'h0) begin
      errors++; $display("FAIL reset_data: instr=%h pc=%h pc4=%h, need 0", out_instr, out_pc, out_pc_plus4);
    end
    do_reset();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      errors++; $display("FAIL reset_release: req=%b addr=%h, need 1/00000000", imem_req, imem_addr);
    end
  endtask

  task automatic test_sequential();
    do_reset();
    run_until_acc(4, 40, "sequential");
    for (int i = 0; i < 3; i++) begin
      if (gnt_addr_q.size() > i) begin
        checks++;
        if (gnt_addr_q[i] !== 32'(i * 4)) begin
          errors++; $display("FAIL seq_addr[%0d]: got %h need %h", i, gnt_addr_q[i], 32'(i * 4));
        end
      end
    end
    for (int i = 0; i < acc_q.size(); i++) begin
      checks++;
      if (acc_q[i].pc !== 32'(i * 4) || acc_q[i].p4 !== 32'(i * 4 + 4) || acc_q[i].instr !== mem_word(32'(i * 4))) begin
        errors++; $display("FAIL seq_out[%0d]: pc=%h pc4=%h instr=%h need pc=%h", i, acc_q[i].pc, acc_q[i].p4, acc_q[i].instr, 32'(i * 4));
      end
    end
    for (int i = 1; i < acc_gap_q.size(); i++) begin
      checks++;
      if (acc_gap_q[i] != 3) begin
        errors++; $display("FAIL seq_gap[%0d]: got %0d cycles need 3", i, acc_gap_q[i]);
      end
    end
  endtask

  task automatic test_hold();
    logic [31:0] h_instr, h_pc;
    int n_gnt, k;
    do_reset();
    ready_set = 1'b0;
    k = 0;
    while (!out_valid && k < 20) begin cycle(); k++; end
    h_instr = out_instr; h_pc = out_pc; n_gnt = gnt_addr_q.size();
    for (int i = 0; i < 5; i++) begin
      cycle();
      checks++;
      if (out_valid !== 1'b1 || out_instr !== h_instr || out_pc !== h_pc || imem_req !== 1'b0) begin
        errors++; $display("FAIL hold[%0d]: valid=%b instr=%h pc=%h req=%b need 1/%h/%h/0", i, out_valid, out_instr, out_pc, imem_req, h_instr, h_pc);
      end
    end
    checks++;
    if (gnt_addr_q.size() != n_gnt) begin
      errors++; $display("FAIL hold_nofetch: grants %0d need %0d", gnt_addr_q.size(), n_gnt);
    end
    ready_set = 1'b1;
    run_until_acc(1, 10, "hold_release");
    if (acc_q.size() > 0) begin
      checks++;
      if (acc_q[0].pc !== 32'h0 || acc_q[0].instr !== mem_word(32'h0)) begin
        errors++; $display("FAIL hold_accept: pc=%h instr=%h need 00000000/%h", acc_q[0].pc, acc_q[0].instr, mem_word(32'h0));
      end
    end
  endtask

  task automatic test_beq_wait();
    int n_gnt, k;
    do_reset();
    dly_min = 2; dly_max = 2;
    run_until_acc(1, 20, "beq_first");
    k = 0;
    while (!pend && k < 20) begin cycle(); k++; end
    stage_br(3'b001, 32'h10, 32'h3, 32'h0, 26'h0, 1'b1);
    n_gnt = gnt_addr_q.size();
    cycle();
    run_until_acc(2, 30, "beq_after");
    if (gnt_addr_q.size() > n_gnt) begin
      checks++;
      if (gnt_addr_q[n_gnt] !== 32'h20) begin
        errors++; $display("FAIL beq_next_addr: got %h need 00000020", gnt_addr_q[n_gnt]);
      end
    end
    if (acc_q.size() > 1) begin
      checks++;
      if (acc_q[1].pc !== 32'h20 || acc_q[1].instr !== mem_word(32'h20)) begin
        errors++; $display("FAIL beq_deliver: pc=%h need 00000020", acc_q[1].pc);
      end
    end
    checks++;
    if (flush_viol != 0) begin
      errors++; $display("FAIL beq_flush: %0d flushed words shown valid, need 0", flush_viol);
    end
  endtask

  task automatic test_bgtz();
    do_reset();
    run_until_acc(1, 20, "bgtz_first");
    stage_br(3'b101, 32'h40, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 26'h0, 1'b0);
    run_until_acc(2, 20, "bgtz_nt");
    if (acc_q.size() > 1) begin
      checks++;
      if (acc_q[1].pc !== 32'h4) begin
        errors++; $display("FAIL bgtz_not_taken: pc=%h need 00000004", acc_q[1].pc);
      end
    end
    stage_br(3'b101, 32'h40, 32'hFFFF_FFFE, 32'h1, 26'h0, 1'b0);
    run_until_acc(3, 20, "bgtz_t");
    if (acc_q.size() > 2) begin
      checks++;
      if (acc_q[2].pc !== 32'h3C || acc_q[2].p4 !== 32'h40) begin
        errors++; $display("FAIL bgtz_taken: pc=%h pc4=%h need 0000003c/00000040", acc_q[2].pc, acc_q[2].p4);
      end
    end
  endtask

  task automatic test_jumps();
    int k, n_acc;
    do_reset();
    stage_br(3'b100, 32'h8000_0010, 32'h0, 32'h0, 26'h000_0040, 1'b0);
    run_until_acc(1, 20, "j");
    if (acc_q.size() > 0) begin
      checks++;
      if (acc_q[0].pc !== 32'h8000_0100) begin
        errors++; $display("FAIL j_target: pc=%h need 80000100", acc_q[0].pc);
      end
    end
    stage_br(3'b011, 32'h0, 32'h0, 32'h1237, 26'h0, 1'b0);
    run_until_acc(2, 20, "jr");
    if (acc_q.size() > 1) begin
      checks++;
      if (acc_q[1].pc !== 32'h1234) begin
        errors++; $display("FAIL jr_target: pc=%h need 00001234", acc_q[1].pc);
      end
    end
    ready_set = 1'b0;
    k = 0;
    while (!out_valid && k < 20) begin cycle(); k++; end
    stage_br(3'b010, 32'h100, 32'h0, 32'h0, 26'h80, 1'b0);
    ready_set = 1'b1;
    n_acc = acc_q.size();
    cycle();
    checks++;
    if (out_valid !== 1'b0 || acc_q.size() != n_acc) begin
      errors++; $display("FAIL hold_redirect: valid=%b accepted=%0d need 0/%0d", out_valid, acc_q.size(), n_acc);
    end
    run_until_acc(n_acc + 1, 20, "jal");
    if (acc_q.size() > n_acc) begin
      checks++;
      if (acc_q[n_acc].pc !== 32'h200) begin
        errors++; $display("FAIL jal_target: pc=%h need 00000200", acc_q[n_acc].pc);
      end
    end
  endtask

  task automatic test_reset_wait();
    int k;
    do_reset();
    dly_min = 2; dly_max = 2;
    run_until_acc(1, 20, "rstw_first");
    k = 0;
    while (!pend && k < 20) begin cycle(); k++; end
    rst = 1'b1;
    #1;
    checks++;
    if (imem_req !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL rstw_assert: req=%b valid=%b need 0/0", imem_req, out_valid);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    pend = 1'b0; imem_gnt = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = mem_word(pend_addr);
    @(posedge clk);
    #1 imem_rvalid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      errors++; $display("FAIL rstw_stale: valid=%b req=%b addr=%h need 0/1/00000000", out_valid, imem_req, imem_addr);
    end
    exp_pc = 32'h0;
    acc_q.delete(); acc_gap_q.delete();
    dly_min = 0; dly_max = 0;
    run_until_acc(1, 20, "rstw_refetch");
    if (acc_q.size() > 0) begin
      checks++;
      if (acc_q[0].pc !== 32'h0 || acc_q[0].instr !== mem_word(32'h0)) begin
        errors++; $display("FAIL rstw_refetch: pc=%h instr=%h need 00000000", acc_q[0].pc, acc_q[0].instr);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    gnt_pct = 60; dly_min = 0; dly_max = 3;
    for (int c = 0; c < 3000; c++) begin
      ready_set = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 99) < 12) begin
        case ($urandom_range(0, 2))
          0: nb_rs1 = 32'h0;
          1: nb_rs1 = $urandom;
          default: nb_rs1 = 32'($urandom_range(1, 10));
        endcase
        stage_br(3'($urandom_range(0, 7)), $urandom, 32'($urandom_range(0, 128)) - 32'd64,
                 nb_rs1, 26'($urandom), $urandom_range(0, 1) == 1);
      end
      cycle();
    end
    checks++;
    if (acc_q.size() < 50) begin
      errors++; $display("FAIL rand_progress: %0d accepted need >= 50", acc_q.size());
    end
    foreach (acc_q[i]) begin
      checks++;
      if (acc_q[i].pc !== acc_q[i].exp || acc_q[i].p4 !== acc_q[i].exp + 32'd4 || acc_q[i].instr !== mem_word(acc_q[i].exp)) begin
        errors++; $display("FAIL rand_out[%0d]: pc=%h pc4=%h instr=%h need pc=%h", i, acc_q[i].pc, acc_q[i].p4, acc_q[i].instr, acc_q[i].exp);
      end
    end
    checks++;
    if (flush_viol != 0 || overlap_viol != 0) begin
      errors++; $display("FAIL rand_protocol: flush_viol=%0d overlap_viol=%0d need 0/0", flush_viol, overlap_viol);
    end
  endtask

  initial begin
    cyc = 0;
    test_reset();
    test_sequential();
    test_hold();
    test_beq_wait();
    test_bgtz();
    test_jumps();
    test_reset_wait();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
